ll_window_sched: RTL and testbench
==================================

Name: ll_window_sched

Overview:
- Multi-channel line-length window scheduler for the EEG feature path.
- Accepts a time-interleaved sample stream (one sample per channel per frame, channels in fixed order).
- Per channel, keeps the previous sample and accumulates |x[n] − x[n−1]| over WIN_LEN frames.
- At window end, drains one line-length result per channel to the feature memory/classifier over a valid/ready stream, then starts the next window.

Parameters:
- DATA_W, 32: sample magnitude width; samples are signed DATA_W+1 bits.
- NUM_CH, 4: channel count; must be ≥2.
- WIN_LEN, 256: frames per window; must be a power of 2, ≥2.
- CH_W, $clog2(NUM_CH): channel index width (derived).
- ACC_W, DATA_W+1+$clog2(WIN_LEN): accumulator/result width (derived); overflow is impossible by construction.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_valid  in  1  input sample valid
- s_ready  out  1  scheduler can accept a sample
- s_ch  in  CH_W  channel tag of input sample
- s_data  in  DATA_W+1  signed sample
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts result
- m_ch  out  CH_W  channel of result
- m_ll  out  ACC_W  unsigned window line length
- m_last  out  1  marks the result for channel NUM_CH−1
- seq_err  out  1  one-cycle pulse: channel tag out of order
- busy  out  1  high while in DRAIN

Behaviour:
- Reset: the following are all 0:
  - outputs: s_ready, m_valid, m_ch, m_ll, m_last, seq_err, busy
  - state: all prev samples, all accumulators, expected-channel counter exp_ch, frame counter
  - FSM state: SEED
- s_ready is 1 from the first cycle after reset is released; it is a registered/state-derived output and never combinationally depends on s_valid.
- Transfer occurs when s_valid && s_ready. Tag check on every transfer:
  - s_ch != exp_ch: sample is consumed and discarded; seq_err pulses the next cycle; exp_ch, accumulators, prev and frame counter are unchanged.
  - s_ch == exp_ch: normal accept.

FSM:
- SEED:
  - Active only for the first frame after reset.
  - Accepted sample is written to prev[ch]; accumulator is unchanged (contribution 0).
  - exp_ch increments. When exp_ch wraps from NUM_CH−1 to 0: frame counter := 1, go to ACCUM.
- ACCUM:
  - Accepted sample: diff = s_data − prev[ch], computed at DATA_W+2 bits signed.
  - acc[ch] += |diff|; prev[ch] := s_data. Both are visible one cycle after the transfer.
  - exp_ch increments and wraps.
  - At wrap, frame counter increments. If it reaches WIN_LEN, the counter clears, s_ready drops in the same edge, and the FSM goes to DRAIN.
- DRAIN:
  - s_ready = 0, busy = 1.
  - Results are presented in order ch 0..NUM_CH−1: m_valid = 1, m_ch = index, m_ll = acc[index], m_last = (index == NUM_CH−1).
  - First result is valid the cycle after the last window sample was accepted; the final accumulator update must already be included.
  - On m_valid && m_ready: acc[index] := 0, index advances. m_valid stays high back-to-back (1 result/cycle at full throughput).
  - After the transfer with m_last: m_valid = 0, return to ACCUM next cycle with s_ready = 1.
  - prev[] is retained, so windows are continuous: the first diff of a new window uses the last sample of the previous one. SEED is never re-entered except by reset.
- Backpressure: while m_valid && !m_ready, m_ch, m_ll and m_last hold stable.
- Reset mid-DRAIN or mid-window: all results are dropped, m_valid falls at the next edge, FSM returns to SEED.
- seq_err during DRAIN cannot occur (no transfers).

Optional Feature:
- Macro: LL_SCHED_NORM_EN.
- Defined: m_ll = acc >> $clog2(WIN_LEN) (mean absolute difference per frame, truncating). Upper $clog2(WIN_LEN) bits of m_ll are 0.
- Undefined: m_ll = raw accumulator.
- All other behaviour is identical in both cases.

Test Plan (NUM_CH=2, WIN_LEN=4, DATA_W=8, macro off unless noted):
- Basic window: ch0 = 10,13,11,15; ch1 = −5,5,5,−5, interleaved, s_valid continuous -> DRAIN outputs (m_ch=0, m_ll=9, m_last=0) then (m_ch=1, m_ll=20, m_last=1); s_ready=0 for exactly 2 cycles with m_ready=1.
- Continuity: following window ch0 = 15,15,15,15; ch1 = −5,−5,−5,−5 -> results 0 and 0. A second run with ch0 = 16 in the first frame of that window -> ch0 result 2.
- Sequence error: send s_ch=1 when ch0 is expected, value 100 -> seq_err pulses once; sample is ignored; basic-window results are still 9/20.
- Backpressure: hold m_ready=0 for 5 cycles in DRAIN -> m_valid=1, m_ch=0, m_ll=9 stable, no input accepted; release -> both results are delivered in order.
- Extremes: ch0 alternates −256, +255 -> |diff| = 511 each; window result 3×511 = 1533. With LL_SCHED_NORM_EN -> 383.
- Reset mid-DRAIN after the ch0 result is accepted -> m_valid=0 next cycle. The next frame is treated as SEED: the first window after reset yields the basic-window values again.

Source files
------------

// File: rtl/ll_window_sched.sv
// Multi-channel line-length window scheduler: accumulates |x[n]-x[n-1]| per channel
// over WIN_LEN frames, then drains one result per channel. Build option: LL_SCHED_NORM_EN.
//
// state | meaning
// SEED  | first frame after reset, loads prev[] only
// ACCUM | accumulating line length, accepting samples
// DRAIN | presenting one result per channel, input stalled
module ll_window_sched #(
  parameter int DATA_W  = 32,
  parameter int NUM_CH  = 4,
  parameter int WIN_LEN = 256,
  parameter int CH_W    = $clog2(NUM_CH),
  parameter int ACC_W   = DATA_W + 1 + $clog2(WIN_LEN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [CH_W-1:0]          s_ch,
  input  logic signed [DATA_W:0]   s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [CH_W-1:0]          m_ch,
  output logic [ACC_W-1:0]         m_ll,
  output logic                     m_last,
  output logic                     seq_err,
  output logic                     busy
);

  localparam int LOG_WIN = $clog2(WIN_LEN);
  localparam logic [CH_W-1:0]    LAST_CH    = CH_W'(NUM_CH - 1);
  localparam logic [LOG_WIN-1:0] LAST_FRAME = LOG_WIN'(WIN_LEN - 1);

  typedef enum logic [1:0] {SEED, ACCUM, DRAIN} state_t;

  state_t                     state_q, state_d;
  logic [CH_W-1:0]            exp_ch_q;
  logic [CH_W-1:0]            drain_idx_q;
  logic [LOG_WIN-1:0]         frame_q;
  logic signed [DATA_W:0]     prev_q [NUM_CH];
  logic [ACC_W-1:0]           acc_q  [NUM_CH];
  logic                       s_ready_q;
  logic                       seq_err_q;
  logic [ACC_W-1:0]           m_ll_raw;

  logic                       xfer, tag_ok, acc_en, ch_wrap, m_xfer;
  logic signed [DATA_W+1:0]   diff;
  logic [DATA_W:0]            abs_diff;

  assign xfer    = s_valid && s_ready_q;
  assign tag_ok  = (s_ch == exp_ch_q);
  assign acc_en  = xfer && tag_ok;
  assign ch_wrap = (exp_ch_q == LAST_CH);
  assign m_xfer  = (state_q == DRAIN) && m_ready;

  // One extra bit keeps the difference of two full-range samples exact.
  assign diff     = {s_data[DATA_W], s_data} - {prev_q[exp_ch_q][DATA_W], prev_q[exp_ch_q]};
  assign abs_diff = diff[DATA_W+1] ? (DATA_W+1)'(-diff) : diff[DATA_W:0];

  always_ff @(posedge clk) begin
    if (rst) state_q <= SEED;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    m_valid  = 1'b0;
    m_ch     = '0;
    m_ll_raw = '0;
    m_last   = 1'b0;
    busy     = 1'b0;
    case (state_q)
      SEED: begin
        if (acc_en && ch_wrap) state_d = ACCUM;
      end
      ACCUM: begin
        if (acc_en && ch_wrap && (frame_q == LAST_FRAME)) state_d = DRAIN;
      end
      DRAIN: begin
        busy     = 1'b1;
        m_valid  = 1'b1;
        m_ch     = drain_idx_q;
        m_ll_raw = acc_q[drain_idx_q];
        m_last   = (drain_idx_q == LAST_CH);
        if (m_ready && (drain_idx_q == LAST_CH)) state_d = ACCUM;
      end
      default: state_d = SEED;
    endcase
  end

`ifdef LL_SCHED_NORM_EN
  assign m_ll = m_ll_raw >> LOG_WIN;
`else
  assign m_ll = m_ll_raw;
`endif

  assign s_ready = s_ready_q;
  assign seq_err = seq_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_ready_q   <= 1'b0;
      seq_err_q   <= 1'b0;
      exp_ch_q    <= '0;
      drain_idx_q <= '0;
      frame_q     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        prev_q[i] <= '0;
        acc_q[i]  <= '0;
      end
    end else begin
      // Registered from next state so s_ready falls on the same edge DRAIN is entered.
      s_ready_q <= (state_d != DRAIN);
      seq_err_q <= xfer && !tag_ok;
      if (acc_en) begin
        prev_q[exp_ch_q] <= s_data;
        exp_ch_q         <= ch_wrap ? '0 : exp_ch_q + 1'b1;
        if (state_q == ACCUM) acc_q[exp_ch_q] <= acc_q[exp_ch_q] + ACC_W'(abs_diff);
        if (ch_wrap) begin
          if (state_q == SEED)          frame_q <= LOG_WIN'(1);
          else if (frame_q == LAST_FRAME) frame_q <= '0;
          else                          frame_q <= frame_q + 1'b1;
        end
      end
      if (m_xfer) begin
        acc_q[drain_idx_q] <= '0;
        drain_idx_q        <= (drain_idx_q == LAST_CH) ? '0 : drain_idx_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ll_window_sched.sv
// Directed bench for ll_window_sched with NUM_CH=2, WIN_LEN=4, DATA_W=8.
// Honours LL_SCHED_NORM_EN by scaling expected results.
module tb_ll_window_sched;

  localparam int DATA_W  = 8;
  localparam int NUM_CH  = 2;
  localparam int WIN_LEN = 4;
  localparam int ACC_W   = DATA_W + 1 + $clog2(WIN_LEN);
`ifdef LL_SCHED_NORM_EN
  localparam int SH = 2;
`else
  localparam int SH = 0;
`endif

  logic                   clk, rst;
  logic                   s_valid, s_ready;
  logic [0:0]             s_ch;
  logic signed [DATA_W:0] s_data;
  logic                   m_valid, m_ready;
  logic [0:0]             m_ch;
  logic [ACC_W-1:0]       m_ll;
  logic                   m_last, seq_err, busy;

  int n_cmp = 0;
  int n_err = 0;

  ll_window_sched #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .WIN_LEN(WIN_LEN)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_ch(s_ch), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_ch(m_ch), .m_ll(m_ll), .m_last(m_last),
    .seq_err(seq_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; s_ch = '0; s_data = '0; m_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  // Presents one sample and returns #1 after the edge that accepted it.
  task automatic send(input int ch, input int d);
    int cnt;
    cnt = 0;
    s_valid = 1'b1; s_ch = 1'(ch); s_data = (DATA_W+1)'(d);
    while (!s_ready && cnt < 20) begin
      tick();
      cnt++;
    end
    if (cnt >= 20) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout ch=%0d s_ready stayed %0b, required 1", ch, s_ready);
    end
    tick();
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input int a, input int b);
    send(0, a);
    send(1, b);
  endtask

  task automatic basic_window();
    send_frame(10, -5);
    send_frame(13, 5);
    send_frame(11, 5);
    send_frame(15, -5);
  endtask

  // Expects to be called in the first DRAIN cycle with m_ready=1.
  task automatic drain_expect(input string name, input int e0, input int e1);
    n_cmp++;
    if (m_valid !== 1'b1 || m_ch !== 1'b0 || m_ll !== ACC_W'(e0 >> SH) || m_last !== 1'b0 ||
        s_ready !== 1'b0 || busy !== 1'b1 || seq_err !== 1'b0) begin
      n_err++;
      $display("FAIL %s_r0 got v=%0b ch=%0d ll=%0d last=%0b rdy=%0b busy=%0b err=%0b, required v=1 ch=0 ll=%0d last=0 rdy=0 busy=1 err=0",
               name, m_valid, m_ch, m_ll, m_last, s_ready, busy, seq_err, e0 >> SH);
    end
    tick();
    n_cmp++;
    if (m_valid !== 1'b1 || m_ch !== 1'b1 || m_ll !== ACC_W'(e1 >> SH) || m_last !== 1'b1 ||
        s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL %s_r1 got v=%0b ch=%0d ll=%0d last=%0b rdy=%0b, required v=1 ch=1 ll=%0d last=1 rdy=0",
               name, m_valid, m_ch, m_ll, m_last, s_ready, e1 >> SH);
    end
    tick();
    n_cmp++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_end got v=%0b rdy=%0b busy=%0b, required v=0 rdy=1 busy=0",
               name, m_valid, s_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_ch = '0; s_data = '0; m_ready = 1'b1;
    tick(); tick();
    n_cmp++;
    if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_ch !== 1'b0 || m_ll !== '0 ||
        m_last !== 1'b0 || seq_err !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs got rdy=%0b v=%0b ch=%0d ll=%0d last=%0b err=%0b busy=%0b, required all 0",
               s_ready, m_valid, m_ch, m_ll, m_last, seq_err, busy);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_ready got %0b, required 1", s_ready);
    end
  endtask

  task automatic test_basic();
    do_reset();
    basic_window();
    drain_expect("basic", 9, 20);
  endtask

  task automatic test_continuity();
    do_reset();
    basic_window();
    drain_expect("cont_w1", 9, 20);
    for (int i = 0; i < 4; i++) send_frame(15, -5);
    drain_expect("cont_flat", 0, 0);
    do_reset();
    basic_window();
    drain_expect("cont_w1b", 9, 20);
    send_frame(16, -5);
    for (int i = 0; i < 3; i++) send_frame(15, -5);
    drain_expect("cont_step", 2, 0);
  endtask

  task automatic test_seq_err();
    do_reset();
    send(1, 100);
    n_cmp++;
    if (seq_err !== 1'b1) begin
      n_err++;
      $display("FAIL seq_err_pulse got %0b, required 1", seq_err);
    end
    tick();
    n_cmp++;
    if (seq_err !== 1'b0) begin
      n_err++;
      $display("FAIL seq_err_clear got %0b, required 0", seq_err);
    end
    basic_window();
    drain_expect("seq_err", 9, 20);
  endtask

  task automatic test_backpressure();
    do_reset();
    m_ready = 1'b0;
    basic_window();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (m_valid !== 1'b1 || m_ch !== 1'b0 || m_ll !== ACC_W'(9 >> SH) || m_last !== 1'b0 ||
          s_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold%0d got v=%0b ch=%0d ll=%0d last=%0b rdy=%0b, required v=1 ch=0 ll=%0d last=0 rdy=0",
                 i, m_valid, m_ch, m_ll, m_last, s_ready, 9 >> SH);
      end
      tick();
    end
    m_ready = 1'b1;
    drain_expect("bp_release", 9, 20);
  endtask

  task automatic test_extremes();
    do_reset();
    send_frame(-256, 0);
    send_frame(255, 0);
    send_frame(-256, 0);
    send_frame(255, 0);
    drain_expect("extreme", 1533, 0);
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    basic_window();
    tick();
    n_cmp++;
    if (m_valid !== 1'b1 || m_ch !== 1'b1 || m_ll !== ACC_W'(20 >> SH)) begin
      n_err++;
      $display("FAIL mid_drain_r1 got v=%0b ch=%0d ll=%0d, required v=1 ch=1 ll=%0d",
               m_valid, m_ch, m_ll, 20 >> SH);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0 || m_ll !== '0) begin
      n_err++;
      $display("FAIL mid_drain_reset got v=%0b busy=%0b rdy=%0b ll=%0d, required 0 0 0 0",
               m_valid, busy, s_ready, m_ll);
    end
    rst = 1'b0;
    tick();
    basic_window();
    drain_expect("after_reset", 9, 20);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_continuity();
    test_seq_err();
    test_backpressure();
    test_extremes();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
